ball_spawner: RTL and testbench
===============================

BALL_SPAWNER -- requirements
Module: ball_spawner

Interface
REQ-001 Parameter Y_MIN, default 10'd32: lowest legal spawn row.
REQ-002 Parameter Y_MAX, default 10'd447: highest legal spawn row.
REQ-003 Parameter MAX_TRIES, default 8: rejected samples allowed before fallback (range 1..15).
REQ-004 Parameter FALLBACK_Y, default 10'd240: row used when tries are exhausted.
REQ-005 Parameter COOLDOWN, default 4: idle cycles after each launch (range 1..15).
REQ-006 gameclk  input  1  sole clock; all logic on its rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 rnd_in  input  10  free-running pseudo-random word from the game LFSR; changes every cycle.
REQ-009 spawn_req  input  1  request for a new ball; sampled only in IDLE.
REQ-010 launch_ready  input  1  ball logic accepts the offered spawn.
REQ-011 spawn_valid  output  1  ball_y/ball_dir_up hold a valid offer.
REQ-012 ball_y  output  10  spawn row.
REQ-013 ball_dir_up  output  1  initial vertical direction (1 = up).
REQ-014 fallback  output  1  current offer came from FALLBACK_Y.
REQ-015 busy  output  1  high in every state except IDLE.

Function
REQ-016 FSM states: IDLE, SAMPLE, OFFER, COOLDOWN; registered state with a single next-state block.
REQ-017 IDLE: spawn_req=1 -> SAMPLE next cycle and clear the try counter; spawn_req=0 -> stay.
REQ-018 spawn_req outside IDLE is ignored, not queued.
REQ-019 SAMPLE: each cycle, rnd_in is accepted iff Y_MIN <= rnd_in <= Y_MAX (unsigned, inclusive) and rnd_in != 0.
REQ-020 On accept: ball_y <= rnd_in, ball_dir_up <= rnd_in[0], fallback <= 0, go to OFFER.
REQ-021 On reject: try counter increments. When the counter reaches MAX_TRIES on that cycle: ball_y <= FALLBACK_Y, ball_dir_up <= 1, fallback <= 1, go to OFFER.
REQ-022 Latency from a spawn_req cycle to spawn_valid=1 is 2 cycles when the first sample is accepted. The worst case is MAX_TRIES+1 cycles.
REQ-023 OFFER: spawn_valid=1. ball_y, ball_dir_up and fallback stay constant until the handshake.
REQ-024 Handshake occurs on a cycle with spawn_valid=1 and launch_ready=1. The next state is COOLDOWN, with spawn_valid=0 on the following cycle.
REQ-025 launch_ready outside OFFER has no effect.
REQ-026 COOLDOWN: a down-counter loaded with COOLDOWN-1 on entry. The FSM stays exactly COOLDOWN cycles, then returns to IDLE.
REQ-027 ball_y and ball_dir_up keep their last values after launch until the next accept or fallback.
REQ-028 Boundary: rnd_in == Y_MIN and rnd_in == Y_MAX are accepted. rnd_in == Y_MIN-1 and rnd_in == Y_MAX+1 are rejected.
REQ-029 Boundary: rnd_in == 0 (LFSR lock-up value) is always rejected, even if Y_MIN is 0.

Reset
REQ-030 reset=1 at any clock edge forces IDLE, whatever the current state, including a mid-SAMPLE or mid-OFFER operation.
REQ-031 The same reset edge sets spawn_valid=0, busy=0, fallback=0, ball_y=0, ball_dir_up=0, the try counter to 0 and the cooldown counter to 0.
REQ-032 A spawn_req in the same cycle as reset=1 is discarded.
REQ-033 A pending offer is lost on reset; spawn_valid never asserts in the cycle after a reset edge.

Verification
REQ-034 Reset, then spawn_req for 1 cycle with rnd_in=100, launch_ready=1 -> spawn_valid=1 two cycles after the request, ball_y=100, ball_dir_up=0, fallback=0. Then busy stays high 4 further cycles and drops to IDLE.
REQ-035 rnd_in sequence 0, 31, 448, 32 -> three rejects, then ball_y=32, ball_dir_up=0, fallback=0. Repeat with 447 as the final value -> ball_y=447, ball_dir_up=1.
REQ-036 rnd_in held at 1000 with MAX_TRIES=8 -> spawn_valid=1 nine cycles after spawn_req, ball_y=240, ball_dir_up=1, fallback=1.
REQ-037 OFFER with launch_ready=0 for 20 cycles while rnd_in and spawn_req toggle -> ball_y constant, spawn_valid stays 1, no new request is taken. Then launch_ready=1 -> COOLDOWN.
REQ-038 reset=1 during SAMPLE (after 3 rejects) and again during OFFER -> next cycle all outputs are 0 and the FSM is in IDLE. A spawn_req afterwards restarts with a zeroed try counter.

Source files
------------

// File: rtl/ball_spawner.sv
// Picks a random spawn row from the game LFSR. Each sample outside [Y_MIN, Y_MAX] is
// rejected, and FALLBACK_Y is used once MAX_TRIES samples have been rejected.
module ball_spawner #(
    parameter logic [9:0] Y_MIN      = 10'd32,
    parameter logic [9:0] Y_MAX      = 10'd447,
    parameter int         MAX_TRIES  = 8,
    parameter logic [9:0] FALLBACK_Y = 10'd240,
    parameter int         COOLDOWN   = 4
) (
    input  logic       gameclk,
    input  logic       reset,
    input  logic [9:0] rnd_in,
    input  logic       spawn_req,
    input  logic       launch_ready,
    output logic       spawn_valid,
    output logic [9:0] ball_y,
    output logic       ball_dir_up,
    output logic       fallback,
    output logic       busy
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SAMPLE   = 2'd1,
        ST_OFFER    = 2'd2,
        ST_COOLDOWN = 2'd3
    } state_t;

    typedef struct packed {
        logic [9:0] y;
        logic       dir_up;
        logic       fb;
    } offer_t;

    localparam logic [3:0] TRY_LAST = 4'(MAX_TRIES - 1);
    localparam logic [3:0] CD_LOAD  = 4'(COOLDOWN - 1);

    state_t     state, state_nx;
    offer_t     offer, offer_nx;
    logic [3:0] tries, tries_nx;
    logic [3:0] cd_cnt, cd_nx;
    logic       rnd_ok;

    // Zero is the LFSR lock-up value and is never a legal row, whatever Y_MIN is.
    assign rnd_ok = (rnd_in != 10'd0) && (rnd_in >= Y_MIN) && (rnd_in <= Y_MAX);

    always_ff @(posedge gameclk) begin
        if (reset) begin
            state  <= ST_IDLE;
            offer  <= '0;
            tries  <= '0;
            cd_cnt <= '0;
        end else begin
            state  <= state_nx;
            offer  <= offer_nx;
            tries  <= tries_nx;
            cd_cnt <= cd_nx;
        end
    end

    always_comb begin
        state_nx = state;
        offer_nx = offer;
        tries_nx = tries;
        cd_nx    = cd_cnt;
        case (state)
            ST_IDLE: begin
                if (spawn_req) begin
                    state_nx = ST_SAMPLE;
                    tries_nx = '0;
                end
            end
            ST_SAMPLE: begin
                if (rnd_ok) begin
                    offer_nx = '{y: rnd_in, dir_up: rnd_in[0], fb: 1'b0};
                    state_nx = ST_OFFER;
                end else begin
                    tries_nx = tries + 4'd1;
                    if (tries == TRY_LAST) begin
                        offer_nx = '{y: FALLBACK_Y, dir_up: 1'b1, fb: 1'b1};
                        state_nx = ST_OFFER;
                    end
                end
            end
            ST_OFFER: begin
                if (launch_ready) begin
                    state_nx = ST_COOLDOWN;
                    cd_nx    = CD_LOAD;
                end
            end
            ST_COOLDOWN: begin
                if (cd_cnt == 4'd0) state_nx = ST_IDLE;
                else                cd_nx    = cd_cnt - 4'd1;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    assign spawn_valid = (state == ST_OFFER);
    assign busy        = (state != ST_IDLE);
    assign ball_y      = offer.y;
    assign ball_dir_up = offer.dir_up;
    assign fallback    = offer.fb;

endmodule

// File: tb/tb_ball_spawner.sv
// Scoreboard bench for ball_spawner: the expected offer is queued when a request is
// driven and is compared when spawn_valid rises.
module tb_ball_spawner;

    logic       gameclk = 1'b0;
    logic       reset, spawn_req, launch_ready;
    logic [9:0] rnd_in;
    logic       spawn_valid, ball_dir_up, fallback, busy;
    logic [9:0] ball_y;

    typedef struct {
        int y;
        int dir;
        int fb;
        int lat;
    } exp_t;

    exp_t       sb[$];
    logic [9:0] q[$];
    int         checks = 0;
    int         errors = 0;

    ball_spawner dut (
        .gameclk     (gameclk),
        .reset       (reset),
        .rnd_in      (rnd_in),
        .spawn_req   (spawn_req),
        .launch_ready(launch_ready),
        .spawn_valid (spawn_valid),
        .ball_y      (ball_y),
        .ball_dir_up (ball_dir_up),
        .fallback    (fallback),
        .busy        (busy)
    );

    always #5 gameclk = ~gameclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge gameclk);
        #1;
    endtask

    // Reference for the default parameters: window 32..447, 8 tries, fallback row 240.
    function automatic exp_t model(input logic [9:0] seq[$]);
        exp_t e;
        int   tries;
        logic [9:0] r;
        tries = 0;
        e = '{0, 0, 0, 0};
        for (int i = 0; i < 40; i++) begin
            r = seq[(i < seq.size()) ? i : seq.size() - 1];
            if (r != 0 && r >= 32 && r <= 447) begin
                e = '{int'(r), int'(r[0]), 0, i + 2};
                return e;
            end
            tries++;
            if (tries == 8) begin
                e = '{240, 1, 1, i + 2};
                return e;
            end
        end
        return e;
    endfunction

    // One full spawn: request, SAMPLE stream, an OFFER held for 'hold' cycles,
    // handshake, and then the cooldown, during which requests are ignored.
    task automatic spawn(input logic [9:0] seq[$], input exp_t e, input int hold);
        exp_t       got;
        int         cyc;
        int         cnt;
        logic [9:0] y0;
        sb.push_back(e);
        launch_ready = (hold == 0);
        spawn_req    = 1'b1;
        rnd_in       = 10'($urandom);
        step();
        spawn_req = 1'b0;
        cyc = 1;
        while (!spawn_valid && cyc < 40) begin
            rnd_in = seq[(cyc - 1 < seq.size()) ? cyc - 1 : seq.size() - 1];
            step();
            cyc++;
        end
        got = sb.pop_front();
        if (!spawn_valid) begin
            chk("offer_timeout", {31'd0, spawn_valid}, 32'd1);
            return;
        end
        chk("latency", cyc, got.lat);
        chk("ball_y", {22'd0, ball_y}, got.y);
        chk("dir_up", {31'd0, ball_dir_up}, got.dir);
        chk("fallback", {31'd0, fallback}, got.fb);
        y0 = ball_y;
        for (int i = 0; i < hold; i++) begin
            rnd_in    = 10'($urandom);
            spawn_req = 1'($urandom);
            step();
            chk("hold_valid", {31'd0, spawn_valid}, 32'd1);
            chk("hold_y", {22'd0, ball_y}, {22'd0, y0});
        end
        spawn_req    = 1'b0;
        launch_ready = 1'b1;
        step();
        chk("post_hs_valid", {31'd0, spawn_valid}, 32'd0);
        cnt = 0;
        while (busy && cnt < 40) begin
            spawn_req = 1'b1;
            step();
            cnt++;
        end
        spawn_req = 1'b0;
        chk("cooldown_len", cnt, 4);
        step();
        chk("req_ignored", {31'd0, busy}, 32'd0);
        chk("y_kept", {22'd0, ball_y}, {22'd0, y0});
        launch_ready = 1'b0;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        spawn_req = 1'b1;
        step();
        chk("rst_valid", {31'd0, spawn_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_fb", {31'd0, fallback}, 32'd0);
        chk("rst_y", {22'd0, ball_y}, 32'd0);
        chk("rst_dir", {31'd0, ball_dir_up}, 32'd0);
        reset     = 1'b0;
        spawn_req = 1'b0;
        step();
        chk("rst_req_dropped", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        reset        = 1'b1;
        spawn_req    = 1'b0;
        launch_ready = 1'b0;
        rnd_in       = 10'd0;
        step();
        step();
        chk("init_busy", {31'd0, busy}, 32'd0);
        chk("init_valid", {31'd0, spawn_valid}, 32'd0);
        chk("init_y", {22'd0, ball_y}, 32'd0);
        reset = 1'b0;
        step();

        q = {10'd100};
        spawn(q, exp_t'{100, 0, 0, 2}, 0);
        q = {10'd0, 10'd31, 10'd448, 10'd32};
        spawn(q, exp_t'{32, 0, 0, 5}, 0);
        q = {10'd0, 10'd31, 10'd448, 10'd447};
        spawn(q, exp_t'{447, 1, 0, 5}, 1);
        q = {10'd1000};
        spawn(q, exp_t'{240, 1, 1, 9}, 0);
        q = {10'd0, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0, 10'd33};
        spawn(q, exp_t'{33, 1, 0, 9}, 0);
        q = {10'd301};
        spawn(q, exp_t'{301, 1, 0, 2}, 20);

        // Reset in SAMPLE after three rejects.
        spawn_req = 1'b1;
        step();
        spawn_req = 1'b0;
        rnd_in = 10'd0;   step();
        rnd_in = 10'd31;  step();
        rnd_in = 10'd448; step();
        chk("mid_sample_busy", {31'd0, busy}, 32'd1);
        do_reset();
        q = {10'd1, 10'd2, 10'd3, 10'd4, 10'd5, 10'd6, 10'd7, 10'd100};
        spawn(q, exp_t'{100, 0, 0, 9}, 0);

        // Reset in OFFER.
        spawn_req = 1'b1;
        step();
        spawn_req = 1'b0;
        rnd_in = 10'd200;
        step();
        chk("mid_offer_valid", {31'd0, spawn_valid}, 32'd1);
        do_reset();
        q = {10'd1000};
        spawn(q, exp_t'{240, 1, 1, 9}, 2);

        for (int k = 0; k < 6; k++) begin
            q = {};
            for (int j = 0; j < 10; j++) q.push_back(10'($urandom_range(0, 1023)));
            spawn(q, model(q), $urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
